irq_ctrl: RTL and testbench

Machine-mode interrupt controller between the interrupt sources (timer, external, software) and the processor's trap logic. It latches source edges into sticky pending bits and gates them with the CSR enables. It picks the highest-priority cause and presents it to the core over a req/ack handshake, then blocks further requests until the core executes mret. It also supplies the live mip value to the CSR register file and keeps a count of taken interrupts.

---
 rtl/irq_pkg.sv | 30 +++
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_edge_latch.sv | 23 ++
 rtl/irq_ctrl.sv | 106 ++++++++++
 tb/tb_irq_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_e;

  localparam int NUM_SRC = 3;

  // Source slot order inside the packed pending/eligible vectors
  localparam int SRC_MSI = 0;
  localparam int SRC_MTI = 1;
  localparam int SRC_MEI = 2;

  // mie/mip bit positions
  localparam int MSI_BIT = 3;
  localparam int MTI_BIT = 7;
  localparam int MEI_BIT = 11;

  localparam logic [30:0] CODE_MSI   = 31'd3;
  localparam logic [30:0] CODE_MTI   = 31'd7;
  localparam logic [30:0] CODE_MEI   = 31'd11;
  localparam logic [31:0] MCAUSE_IRQ = 32'h8000_0000;

  // Winner among eligible sources: MEI > MSI > MTI
  function automatic logic [1:0] pick_src(input logic [NUM_SRC-1:0] elig);
    if (elig[SRC_MEI])      pick_src = 2'(SRC_MEI);
    else if (elig[SRC_MSI]) pick_src = 2'(SRC_MSI);
    else                    pick_src = 2'(SRC_MTI);
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Core-side trap handshake of the interrupt controller.
interface irq_ctrl_if;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic        in_service;
  logic        irq_ack;
  logic        mret;

  modport master (output irq_req, irq_cause, in_service, input irq_ack, mret);
  modport slave  (input irq_req, irq_cause, in_service, output irq_ack, mret);
endinterface

// File: rtl/irq_edge_latch.sv
// Rising-edge detector feeding a sticky pending bit; a same-cycle set beats clear.
module irq_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic clr,
  output logic pending
);
  logic prev;
  logic evt;

  assign evt = in & ~prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev    <= in;
      pending <= evt | (pending & ~clr);
    end
  end
endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: edge-latched pending, priority select,
// req/ack/mret handshake FSM and a saturating taken-interrupt counter.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [30:0] MSI_CODE = CODE_MSI,
  parameter logic [30:0] MTI_CODE = CODE_MTI,
  parameter logic [30:0] MEI_CODE = CODE_MEI
) (
  input  logic             clk,
  input  logic             rst,
  irq_ctrl_if.master       core,
  input  logic             timer_interrupt,
  input  logic             ext_irq,
  input  logic             sw_irq,
  input  logic             mstatus_mie,
  input  logic [31:0]      mie,
  output logic [31:0]      mip,
  output logic [CNT_W-1:0] irq_count
);

  irq_state_e           state, nxt;
  logic [NUM_SRC-1:0]   src, pend, en, elig, clr;
  logic [NUM_SRC:0]     elig_pad;
  logic [1:0]           win, sel_q;
  logic [31:0]          cause_q;
  logic [30:0]          win_code;
  logic                 ack_take;

  logic unused_mie;
  assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

  assign src      = {ext_irq, timer_interrupt, sw_irq};
  assign en       = {mie[MEI_BIT], mie[MTI_BIT], mie[MSI_BIT]};
  assign elig     = pend & en & {NUM_SRC{mstatus_mie}};
  assign elig_pad = {1'b0, elig};
  assign win      = pick_src(elig);
  assign ack_take = (state == REQ) && core.irq_ack;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign clr[i] = ack_take && (sel_q == 2'(i));
    irq_edge_latch u_lat (
      .clk     (clk),
      .rst     (rst),
      .in      (src[i]),
      .clr     (clr[i]),
      .pending (pend[i])
    );
  end

  always_comb begin
    mip          = '0;
    mip[MSI_BIT] = pend[SRC_MSI];
    mip[MTI_BIT] = pend[SRC_MTI];
    mip[MEI_BIT] = pend[SRC_MEI];
  end

  always_comb begin
    case (win)
      2'(SRC_MEI): win_code = MEI_CODE;
      2'(SRC_MSI): win_code = MSI_CODE;
      default:     win_code = MTI_CODE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Ack outranks a same-cycle loss of enable, so it is tested first
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|elig) nxt = REQ;
      REQ:     if (core.irq_ack) nxt = SERVICE;
               else if (!elig_pad[sel_q]) nxt = IDLE;
      SERVICE: if (core.mret) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    core.irq_req    = (state == REQ);
    core.in_service = (state == SERVICE);
    core.irq_cause  = cause_q;
  end

  // Cause is captured only on IDLE->REQ, freezing it for the whole request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q   <= 2'(SRC_MSI);
      cause_q <= '0;
    end else if (state == IDLE && |elig) begin
      sel_q   <= win;
      cause_q <= MCAUSE_IRQ | {1'b0, win_code};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               irq_count <= '0;
    else if (ack_take && irq_count != '1)   irq_count <= irq_count + 1'b1;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with an expected-cause scoreboard queue.
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        timer_interrupt = 1'b0, ext_irq = 1'b0, sw_irq = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic [31:0] mie = '0;
  logic [31:0] mip;
  logic [3:0]  irq_count;

  irq_ctrl_if bus();

  irq_ctrl #(.CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .core            (bus.master),
    .timer_interrupt (timer_interrupt),
    .ext_irq         (ext_irq),
    .sw_irq          (sw_irq),
    .mstatus_mie     (mstatus_mie),
    .mie             (mie),
    .mip             (mip),
    .irq_count       (irq_count)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] C_MTI = 32'h8000_0007;
  localparam logic [31:0] C_MEI = 32'h8000_000B;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, then pop and compare its expected cause
  task automatic wait_req(input string tag);
    int n = 0;
    logic [31:0] e;
    while (!bus.irq_req && n < 8) begin
      step(1);
      n++;
    end
    chk({tag, "_req"}, 32'(bus.irq_req), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_cause"}, bus.irq_cause, e);
  endtask

  task automatic pulse_timer();
    timer_interrupt = 1'b1; step(1); timer_interrupt = 1'b0;
  endtask

  task automatic do_ack();
    bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
  endtask

  task automatic do_mret();
    bus.mret = 1'b1; step(1); bus.mret = 1'b0;
  endtask

  initial begin
    bus.irq_ack = 1'b0;
    bus.mret    = 1'b0;

    // Reset held: toggling sources has no effect
    for (int i = 0; i < 4; i++) begin
      timer_interrupt = ~timer_interrupt; ext_irq = ~ext_irq; sw_irq = ~sw_irq;
      step(1);
    end
    chk("rst_req",   32'(bus.irq_req), 32'd0);
    chk("rst_cause", bus.irq_cause, 32'd0);
    chk("rst_mip",   mip, 32'd0);
    chk("rst_svc",   32'(bus.in_service), 32'd0);
    chk("rst_cnt",   32'(irq_count), 32'd0);
    timer_interrupt = 0; ext_irq = 0; sw_irq = 0;
    step(1);
    rst = 1'b1; mstatus_mie = 1'b1; mie = 32'h888;
    step(1);

    // Latency: pending after edge k, request after edge k+1
    timer_interrupt = 1'b1;
    exp_q.push_back(C_MTI);
    step(1);
    chk("lat_mip",  mip, 32'h80);
    chk("lat_req0", 32'(bus.irq_req), 32'd0);
    step(1);
    timer_interrupt = 1'b0;
    chk("lat_req1", 32'(bus.irq_req), 32'd1);
    wait_req("lat");
    do_ack();
    chk("ack_svc", 32'(bus.in_service), 32'd1);
    chk("ack_req", 32'(bus.irq_req), 32'd0);
    chk("ack_mip", mip, 32'd0);
    chk("ack_cnt", 32'(irq_count), 32'd1);
    do_mret();
    chk("mret_svc", 32'(bus.in_service), 32'd0);

    // Priority: MEI beats MTI on the same edge
    ext_irq = 1'b1; timer_interrupt = 1'b1;
    exp_q.push_back(C_MEI);
    exp_q.push_back(C_MTI);
    step(1);
    ext_irq = 1'b0; timer_interrupt = 1'b0;
    wait_req("prio1");
    do_ack();
    chk("prio_mip", mip, 32'h80);
    do_mret();
    wait_req("prio2");
    chk("prio_cnt", 32'(irq_count), 32'd2);
    do_ack();
    do_mret();

    // Freeze: higher-priority event during REQ only sets pending
    pulse_timer();
    exp_q.push_back(C_MTI);
    wait_req("frz1");
    ext_irq = 1'b1;
    step(1);
    chk("frz_cause", bus.irq_cause, C_MTI);
    chk("frz_mip0",  mip, 32'h880);
    step(1);
    chk("frz_cause2", bus.irq_cause, C_MTI);
    do_ack();
    ext_irq = 1'b0;
    chk("frz_mip1", mip, 32'h800);
    chk("frz_cnt",  32'(irq_count), 32'd4);
    do_mret();
    exp_q.push_back(C_MEI);
    wait_req("frz2");
    do_ack();
    do_mret();

    // Withdraw on loss of global enable, reassert when restored
    pulse_timer();
    exp_q.push_back(C_MTI);
    wait_req("wd1");
    mstatus_mie = 1'b0;
    step(1);
    chk("wd_req", 32'(bus.irq_req), 32'd0);
    chk("wd_mip", mip, 32'h80);
    chk("wd_svc", 32'(bus.in_service), 32'd0);
    step(2);
    chk("wd_idle", 32'(bus.irq_req), 32'd0);
    mstatus_mie = 1'b1;
    exp_q.push_back(C_MTI);
    wait_req("wd2");
    do_ack();
    do_mret();
    chk("wd_cnt", 32'(irq_count), 32'd6);

    // Set-wins: new MTI edge on the same cycle as its ack
    pulse_timer();
    exp_q.push_back(C_MTI);
    wait_req("sw1");
    timer_interrupt = 1'b1;
    do_ack();
    chk("sw_mip", mip, 32'h80);
    chk("sw_svc", 32'(bus.in_service), 32'd1);
    do_mret();
    exp_q.push_back(C_MTI);
    wait_req("sw2");
    do_ack();
    chk("sw_mip2", mip, 32'h0);
    do_mret();
    step(20);
    chk("hold_req", 32'(bus.irq_req), 32'd0);
    chk("hold_mip", mip, 32'h0);
    timer_interrupt = 1'b0;
    step(1);

    // Ack outside REQ is ignored
    do_ack();
    chk("stray_svc", 32'(bus.in_service), 32'd0);
    chk("stray_cnt", 32'(irq_count), 32'd8);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      pulse_timer();
      exp_q.push_back(C_MTI);
      wait_req("sat");
      do_ack();
      do_mret();
    end
    chk("sat_cnt", 32'(irq_count), 32'hF);

    // Async reset mid-SERVICE with another source pending
    pulse_timer();
    exp_q.push_back(C_MTI);
    wait_req("ar");
    do_ack();
    ext_irq = 1'b1;
    step(1);
    chk("ar_pre_svc", 32'(bus.in_service), 32'd1);
    chk("ar_pre_mip", mip, 32'h800);
    #2 rst = 1'b0;
    #1;
    chk("ar_svc", 32'(bus.in_service), 32'd0);
    chk("ar_mip", mip, 32'd0);
    chk("ar_cnt", 32'(irq_count), 32'd0);
    chk("ar_req", 32'(bus.irq_req), 32'd0);
    ext_irq = 1'b0;
    step(1);
    rst = 1'b1;
    step(3);
    chk("ar_post_req", 32'(bus.irq_req), 32'd0);
    chk("ar_post_mip", mip, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
